// File: rtl/seq_display.sv
// seq_display: builds a pseudo-random five-step one-hot button sequence,
// hands it to the verifier with a one-cycle newSequence strobe, then plays
// the first N steps on the game LEDs and strobes display_done at the end.
// A replay request shows the stored sequence again without regenerating it.
module seq_display #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        replay,
  input  logic [2:0]  LVL,
  output logic [19:0] Sequence,
  output logic        newSequence,
  output logic [3:0]  leds,
  output logic        display_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_LOAD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [19:0]       seq_q, seq_d;
  logic              new_seq_q, new_seq_d;
  logic [3:0]        leds_q, leds_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  // step_q doubles as the nibble counter while generating; it is back to 0
  // before the display starts.
  logic [2:0]        step_q, step_d;
  logic [2:0]        n_q, n_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [2:0]        step_nx;

  // Map a 2-bit random value to a one-hot button code.
  function automatic logic [3:0] onehot2(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  // Extract step k of the sequence; step 0 sits in the top nibble.
  function automatic logic [3:0] nibble_at(input logic [19:0] s, input logic [2:0] k);
    logic [3:0] r;
    case (k)
      3'd0:    r = s[19:16];
      3'd1:    r = s[15:12];
      3'd2:    r = s[11:8];
      3'd3:    r = s[7:4];
      3'd4:    r = s[3:0];
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Number of steps actually shown: at least one, at most the five stored.
  function automatic logic [2:0] clamp_lvl(input logic [2:0] l);
    logic [2:0] r;
    if (l == 3'd0)      r = 3'd1;
    else if (l > 3'd5)  r = 3'd5;
    else                r = l;
    return r;
  endfunction

  assign step_nx = step_q + 3'd1;

  // Next-state and next-output logic; every output is loaded from here.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    seq_d     = seq_q;
    new_seq_d = 1'b0;
    leds_d    = leds_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    step_d    = step_q;
    n_d       = n_q;
    timer_d   = timer_q;

    case (state_q)
      S_IDLE: begin
        leds_d = 4'b0000;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_GEN;
          busy_d  = 1'b1;
          n_d     = clamp_lvl(LVL);
          step_d  = 3'd0;
        end else if (replay) begin
          state_d = S_SHOW_ON;
          busy_d  = 1'b1;
          n_d     = clamp_lvl(LVL);
          step_d  = 3'd0;
          timer_d = '0;
          leds_d  = nibble_at(seq_q, 3'd0);
        end
      end

      S_GEN: begin
        seq_d = {seq_q[15:0], onehot2(lfsr_q[1:0])};
        if (step_q == 3'd4) begin
          step_d    = 3'd0;
          state_d   = S_LOAD;
          new_seq_d = 1'b1;
        end else begin
          step_d = step_nx;
        end
      end

      S_LOAD: begin
        state_d = S_SHOW_ON;
        timer_d = '0;
        leds_d  = nibble_at(seq_q, 3'd0);
      end

      S_SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          leds_d  = 4'b0000;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SHOW_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (step_nx < n_q) begin
            step_d  = step_nx;
            leds_d  = nibble_at(seq_q, step_nx);
            state_d = S_SHOW_ON;
          end else begin
            step_d  = 3'd0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        step_d  = 3'd0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        leds_d  = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset aborts any activity immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      seq_q     <= 20'h0;
      new_seq_q <= 1'b0;
      leds_q    <= 4'b0000;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      step_q    <= 3'd0;
      n_q       <= 3'd1;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      seq_q     <= seq_d;
      new_seq_q <= new_seq_d;
      leds_q    <= leds_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      step_q    <= step_d;
      n_q       <= n_d;
      timer_q   <= timer_d;
    end
  end

  assign Sequence     = seq_q;
  assign newSequence  = new_seq_q;
  assign leds         = leds_q;
  assign display_done = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seq_display.sv
// Self-checking bench for seq_display with short on/off timing.
module tb_seq_display;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        replay;
  logic [2:0]  lvl;
  logic [19:0] sequence_o;
  logic        new_seq;
  logic [3:0]  leds;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [19:0] exp_seq;

  seq_display #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .start(start), .replay(replay), .LVL(lvl),
    .Sequence(sequence_o), .newSequence(new_seq), .leds(leds),
    .display_done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Free-running reference LFSR, clocked like the design's.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [3:0] nib(input logic [19:0] s, input int k);
    logic [19:0] t;
    t = s >> (16 - 4 * k);
    return t[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_leds"},  32'(leds), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_newseq"}, 32'(new_seq), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_seq"},   32'(sequence_o), 32'd0);
  endtask

  // One request and its whole display window, compared cycle by cycle.
  // inject_k: cycle at which start+replay are pulsed mid-flight (-1 = none).
  // reset_k:  cycle at which reset is asserted (-1 = none).
  task automatic run_txn(input bit use_start, input bit use_replay,
                         input logic [2:0] l, input int inject_k, input int reset_k);
    int n, base, last, off;
    logic [15:0] lf;
    logic [19:0] pred;
    logic [3:0]  exp_leds;
    n = (l == 3'd0) ? 1 : ((l > 3'd5) ? 5 : int'(l));
    @(posedge clk);
    #1;
    start  = use_start;
    replay = use_replay;
    lvl    = l;
    lf     = m_lfsr;
    pred   = 20'h0;
    if (use_start) begin
      for (int i = 0; i < 5; i++) begin
        lf   = lfsr_step(lf);
        pred = {pred[15:0], 4'b0001 << lf[1:0]};
      end
    end
    base = use_start ? 7 : 1;
    last = base + n * P;
    @(posedge clk);
    #1;
    start  = 1'b0;
    replay = 1'b0;
    lvl    = 3'($urandom);
    if (use_start) exp_seq = pred;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      start  = (k == inject_k);
      replay = (k == inject_k);
      if (k == reset_k) begin
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        exp_seq = 20'h0;
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        rst    = 1'b1;
        start  = 1'b0;
        replay = 1'b0;
        repeat (P) begin
          @(negedge clk);
          check_zero("rst_after");
        end
        return;
      end
      exp_leds = 4'b0000;
      if (k >= base && k < last) begin
        off = k - base;
        if ((off % P) < ON) exp_leds = nib(exp_seq, off / P);
      end
      check("busy",   32'(busy), 32'(k <= last));
      check("newseq", 32'(new_seq), 32'(use_start && k == 6));
      check("leds",   32'(leds), 32'(exp_leds));
      check("done",   32'(done), 32'(k == last));
      if (!use_start || k >= 6) check("seq", 32'(sequence_o), 32'(exp_seq));
      if (use_start && k == 6) begin
        for (int j = 0; j < 5; j++) check("onehot", 32'($onehot(nib(sequence_o, j))), 32'd1);
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    replay  = 1'b0;
    lvl     = 3'd0;
    exp_seq = 20'h0;

    // Reset held while start toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      check_zero("reset");
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_zero("idle");
    end

    // New sequence, replay, level clamp.
    run_txn(1'b1, 1'b0, 3'd3, -1, -1);
    run_txn(1'b0, 1'b1, 3'd5, -1, -1);
    run_txn(1'b1, 1'b0, 3'd0, -1, -1);
    run_txn(1'b1, 1'b0, 3'd7, -1, -1);

    // Requests while busy are ignored; start wins over replay.
    run_txn(1'b0, 1'b1, 3'd3, 3, -1);
    run_txn(1'b1, 1'b0, 3'd2, 9, -1);
    run_txn(1'b1, 1'b1, 3'd4, -1, -1);

    // Randomized traffic.
    for (int r = 0; r < 8; r++) begin
      bit s;
      bit p;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      s = 1'($urandom);
      p = s ? 1'($urandom) : 1'b1;
      run_txn(s, p, 3'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1, -1);
    end

    // Reset during the second step of a four-step show, then replay zeros.
    run_txn(1'b1, 1'b0, 3'd4, -1, 7 + P + 1);
    run_txn(1'b0, 1'b1, 3'($urandom), -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
